// File: rtl/popcnt_frame_acc.sv
// Framed population-count accumulator: sums set bits per frame over valid/ready.
// Optional macro POPCNT_FRAME_ACC_PIPE_EN adds a popcnt register stage and CLOSE state.
module popcnt_frame_acc #(
    parameter int W         = 32,
    parameter int MAX_BEATS = 256
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  in_vld,
    input  logic [W-1:0]                          in_data,
    input  logic                                  in_last,
    output logic                                  in_rdy,
    output logic                                  out_vld,
    output logic [$clog2(W*MAX_BEATS):0]          out_cnt,
    output logic [$clog2(MAX_BEATS):0]            out_beats,
    output logic                                  out_ovf,
    input  logic                                  out_rdy
);

    localparam int CW = $clog2(W*MAX_BEATS) + 1;
    localparam int BW = $clog2(MAX_BEATS) + 1;
    localparam int PW = $clog2(W) + 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ACC   = 2'd1;
    localparam logic [1:0] S_HOLD  = 2'd2;
`ifdef POPCNT_FRAME_ACC_PIPE_EN
    localparam logic [1:0] S_CLOSE = 2'd3;
`endif

    function automatic logic [PW-1:0] popcnt(input logic [W-1:0] d);
        logic [PW-1:0] c;
        c = '0;
        for (int i = 0; i < W; i++) begin
            c = c + PW'(d[i]);
        end
        return c;
    endfunction

    logic [1:0]    r_state;
    logic [1:0]    w_nxt;
    logic          r_in_rdy;
    logic [CW-1:0] r_acc;
    logic [BW-1:0] r_beats;
    logic          r_ovf;
    logic [CW-1:0] r_out_cnt;
    logic [BW-1:0] r_out_beats;
    logic          r_out_ovf;

    logic          w_accept;
    logic          w_out_hs;
    logic [PW-1:0] w_pc;
    logic          w_s_vld;
    logic          w_s_last;
    logic [PW-1:0] w_s_cnt;
    logic [CW:0]   w_sum;
    logic          w_sat;
    logic [CW-1:0] w_acc_nxt;
    logic          w_full;
    logic [BW-1:0] w_beats_nxt;
    logic          w_ovf_nxt;

    assign w_accept = in_vld && r_in_rdy;
    assign w_out_hs = (r_state == S_HOLD) && out_rdy;
    assign w_pc     = popcnt(in_data);

`ifdef POPCNT_FRAME_ACC_PIPE_EN
    logic          r_p_vld;
    logic          r_p_last;
    logic [PW-1:0] r_p_cnt;

    // Register the per-beat count so the adder sees a clean input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_p_vld  <= 1'b0;
            r_p_last <= 1'b0;
            r_p_cnt  <= '0;
        end else begin
            r_p_vld  <= w_accept;
            r_p_last <= in_last;
            r_p_cnt  <= w_pc;
        end
    end

    assign w_s_vld  = r_p_vld;
    assign w_s_last = r_p_last;
    assign w_s_cnt  = r_p_cnt;
`else
    assign w_s_vld  = w_accept;
    assign w_s_last = in_last;
    assign w_s_cnt  = w_pc;
`endif

    assign w_sum       = {1'b0, r_acc} + (CW+1)'(w_s_cnt);
    assign w_sat       = w_sum[CW];
    assign w_acc_nxt   = w_sat ? {CW{1'b1}} : w_sum[CW-1:0];
    assign w_full      = (r_beats == BW'(MAX_BEATS));
    assign w_beats_nxt = w_full ? r_beats : r_beats + 1'b1;
    assign w_ovf_nxt   = r_ovf | w_full | w_sat;

    // Next-state decode driven by input accepts and the output handshake.
    always_comb begin
        w_nxt = r_state;
        case (r_state)
            S_IDLE, S_ACC: begin
                if (w_accept) begin
`ifdef POPCNT_FRAME_ACC_PIPE_EN
                    w_nxt = in_last ? S_CLOSE : S_ACC;
`else
                    w_nxt = in_last ? S_HOLD : S_ACC;
`endif
                end
            end
`ifdef POPCNT_FRAME_ACC_PIPE_EN
            S_CLOSE: w_nxt = S_HOLD;
`endif
            S_HOLD: begin
                if (out_rdy) w_nxt = S_IDLE;
            end
            default: w_nxt = S_IDLE;
        endcase
    end

    // State register and registered ready (low in reset, high after first edge).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_in_rdy <= 1'b0;
        end else begin
            r_state  <= w_nxt;
            r_in_rdy <= (w_nxt == S_IDLE) || (w_nxt == S_ACC);
        end
    end

    // Running frame accumulator; cleared once the result is taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc   <= '0;
            r_beats <= '0;
            r_ovf   <= 1'b0;
        end else if (w_out_hs) begin
            r_acc   <= '0;
            r_beats <= '0;
            r_ovf   <= 1'b0;
        end else if (w_s_vld && !w_s_last) begin
            r_acc   <= w_acc_nxt;
            r_beats <= w_beats_nxt;
            r_ovf   <= w_ovf_nxt;
        end
    end

    // Result registers load on the closing beat and hold afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_cnt   <= '0;
            r_out_beats <= '0;
            r_out_ovf   <= 1'b0;
        end else if (w_s_vld && w_s_last) begin
            r_out_cnt   <= w_acc_nxt;
            r_out_beats <= w_beats_nxt;
            r_out_ovf   <= w_ovf_nxt;
        end
    end

    assign in_rdy    = r_in_rdy;
    assign out_vld   = (r_state == S_HOLD);
    assign out_cnt   = r_out_cnt;
    assign out_beats = r_out_beats;
    assign out_ovf   = r_out_ovf;

endmodule

// File: tb/tb_popcnt_frame_acc.sv
// Directed bench for popcnt_frame_acc (W=32, MAX_BEATS=4).
// Latency expectations follow POPCNT_FRAME_ACC_PIPE_EN when defined.
module tb_popcnt_frame_acc;

    localparam int W  = 32;
    localparam int MB = 4;
    localparam int CW = $clog2(W*MB) + 1;
    localparam int BW = $clog2(MB) + 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_vld = 1'b0;
    logic [W-1:0]  in_data = '0;
    logic          in_last = 1'b0;
    logic          in_rdy;
    logic          out_vld;
    logic [CW-1:0] out_cnt;
    logic [BW-1:0] out_beats;
    logic          out_ovf;
    logic          out_rdy = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    popcnt_frame_acc #(.W(W), .MAX_BEATS(MB)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_vld    (in_vld),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_rdy    (in_rdy),
        .out_vld   (out_vld),
        .out_cnt   (out_cnt),
        .out_beats (out_beats),
        .out_ovf   (out_ovf),
        .out_rdy   (out_rdy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [W-1:0] d, input logic l);
        int n;
        n = 0;
        in_vld  = 1'b1;
        in_data = d;
        in_last = l;
        while (!in_rdy && n < 20) begin
            step();
            n++;
        end
        n_cmp++;
        if (n >= 20) begin
            n_bad++;
            $display("FAIL beat_accept_timeout: in_rdy=%0b required 1", in_rdy);
        end
        step();
        in_vld = 1'b0;
    endtask

    task automatic wait_result();
`ifdef POPCNT_FRAME_ACC_PIPE_EN
        n_cmp++;
        if (out_vld !== 1'b0) begin
            n_bad++;
            $display("FAIL close_vld: got %0b required 0", out_vld);
        end
        n_cmp++;
        if (in_rdy !== 1'b0) begin
            n_bad++;
            $display("FAIL close_rdy: got %0b required 0", in_rdy);
        end
        step();
`endif
        n_cmp++;
        if (out_vld !== 1'b1) begin
            n_bad++;
            $display("FAIL result_vld: got %0b required 1", out_vld);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        n_cmp++;
        if (in_rdy !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_in_rdy: got %0b required 0", in_rdy);
        end
        n_cmp++;
        if ({out_vld, out_cnt, out_beats, out_ovf} !== '0) begin
            n_bad++;
            $display("FAIL rst_outputs: vld=%0b cnt=%0d beats=%0d ovf=%0b required all 0",
                     out_vld, out_cnt, out_beats, out_ovf);
        end
        rst_n = 1'b1;
        step();
        n_cmp++;
        if (in_rdy !== 1'b1) begin
            n_bad++;
            $display("FAIL rst_release_rdy: got %0b required 1", in_rdy);
        end
    endtask

    task automatic test_single();
        out_rdy = 1'b1;
        beat(32'hFFFF_FFFF, 1'b1);
        wait_result();
        n_cmp++;
        if (out_cnt !== 8'd32 || out_beats !== 3'd1 || out_ovf !== 1'b0) begin
            n_bad++;
            $display("FAIL single_result: cnt=%0d beats=%0d ovf=%0b required 32 1 0",
                     out_cnt, out_beats, out_ovf);
        end
        n_cmp++;
        if (in_rdy !== 1'b0) begin
            n_bad++;
            $display("FAIL single_hold_rdy: got %0b required 0", in_rdy);
        end
        step();
        n_cmp++;
        if (out_vld !== 1'b0 || in_rdy !== 1'b1) begin
            n_bad++;
            $display("FAIL single_release: vld=%0b rdy=%0b required 0 1", out_vld, in_rdy);
        end
        n_cmp++;
        if (out_cnt !== 8'd32) begin
            n_bad++;
            $display("FAIL single_cnt_kept: got %0d required 32", out_cnt);
        end
    endtask

    task automatic test_gap();
        out_rdy = 1'b1;
        beat(32'h0000_000F, 1'b0);
        step();
        beat(32'h0000_0000, 1'b0);
        beat(32'h8000_0001, 1'b1);
        wait_result();
        n_cmp++;
        if (out_cnt !== 8'd6 || out_beats !== 3'd3 || out_ovf !== 1'b0) begin
            n_bad++;
            $display("FAIL gap_result: cnt=%0d beats=%0d ovf=%0b required 6 3 0",
                     out_cnt, out_beats, out_ovf);
        end
        step();
        n_cmp++;
        if (out_vld !== 1'b0) begin
            n_bad++;
            $display("FAIL gap_pulse: got %0b required 0", out_vld);
        end
    endtask

    task automatic test_backpressure();
        out_rdy = 1'b0;
        beat(32'h0000_0003, 1'b1);
        wait_result();
        in_vld  = 1'b1;
        in_data = 32'h0000_00FF;
        in_last = 1'b1;
        for (int i = 0; i < 5; i++) begin
            n_cmp++;
            if (out_vld !== 1'b1 || in_rdy !== 1'b0 ||
                out_cnt !== 8'd2 || out_beats !== 3'd1) begin
                n_bad++;
                $display("FAIL bp_hold[%0d]: vld=%0b rdy=%0b cnt=%0d beats=%0d required 1 0 2 1",
                         i, out_vld, in_rdy, out_cnt, out_beats);
            end
            step();
        end
        out_rdy = 1'b1;
        step();
        out_rdy = 1'b0;
        n_cmp++;
        if (out_vld !== 1'b0 || in_rdy !== 1'b1) begin
            n_bad++;
            $display("FAIL bp_release: vld=%0b rdy=%0b required 0 1", out_vld, in_rdy);
        end
        beat(32'h0000_00FF, 1'b1);
        wait_result();
        n_cmp++;
        if (out_cnt !== 8'd8 || out_beats !== 3'd1) begin
            n_bad++;
            $display("FAIL bp_next: cnt=%0d beats=%0d required 8 1", out_cnt, out_beats);
        end
        out_rdy = 1'b1;
        step();
    endtask

    task automatic test_ovf();
        out_rdy = 1'b1;
        for (int i = 0; i < 5; i++) beat(32'h1, (i == 4));
        wait_result();
        n_cmp++;
        if (out_cnt !== 8'd5 || out_beats !== 3'd4 || out_ovf !== 1'b1) begin
            n_bad++;
            $display("FAIL ovf_frame: cnt=%0d beats=%0d ovf=%0b required 5 4 1",
                     out_cnt, out_beats, out_ovf);
        end
        step();
        beat(32'h1, 1'b1);
        wait_result();
        n_cmp++;
        if (out_cnt !== 8'd1 || out_beats !== 3'd1 || out_ovf !== 1'b0) begin
            n_bad++;
            $display("FAIL ovf_clear: cnt=%0d beats=%0d ovf=%0b required 1 1 0",
                     out_cnt, out_beats, out_ovf);
        end
        n_cmp++;
        if (out_vld !== 1'b1) begin
            n_bad++;
            $display("FAIL ovf_clear_vld: got %0b required 1", out_vld);
        end
        step();
    endtask

    task automatic test_reset_mid();
        int pulses;
        out_rdy = 1'b1;
        beat(32'h7, 1'b0);
        beat(32'h7, 1'b0);
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (in_rdy !== 1'b0 || out_cnt !== 8'd0) begin
            n_bad++;
            $display("FAIL mid_rst_async: rdy=%0b cnt=%0d required 0 0", in_rdy, out_cnt);
        end
        step();
        rst_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (out_vld) pulses++;
        end
        n_cmp++;
        if (pulses != 0) begin
            n_bad++;
            $display("FAIL mid_rst_no_output: pulses=%0d required 0", pulses);
        end
        beat(32'h3, 1'b1);
        wait_result();
        n_cmp++;
        if (out_cnt !== 8'd2 || out_beats !== 3'd1 || out_ovf !== 1'b0) begin
            n_bad++;
            $display("FAIL mid_rst_next: cnt=%0d beats=%0d ovf=%0b required 2 1 0",
                     out_cnt, out_beats, out_ovf);
        end
        step();
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        #1;
        test_reset();
        test_single();
        test_gap();
        test_backpressure();
        test_ovf();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
